// File: rtl/aw_block_gate_pkg.sv
// aw_block_gate_pkg
//   Shared widths, AW transaction type codes and the gate FSM state type
//   for the write-address admission stage.
package aw_block_gate_pkg;

    localparam int PID_WIDTH     = 4;
    localparam int PAWUSER_WIDTH = 2;

    // Transaction type codes carried on awuser. Codes not listed here
    // are handled exactly like REGULAR.
    localparam logic [PAWUSER_WIDTH-1:0] REGULAR = 2'b00;
    localparam logic [PAWUSER_WIDTH-1:0] BLOCK   = 2'b01;
    localparam logic [PAWUSER_WIDTH-1:0] DIVERT  = 2'b10;

    typedef enum logic [2:0] {
        PASS,
        DRAIN,
        ISSUE,
        WAIT_FIN,
        ACK
    } gate_state_t;

    function automatic logic is_block(input logic [PAWUSER_WIDTH-1:0] user);
        return user == BLOCK;
    endfunction

endpackage

// File: rtl/aw_block_gate_counter.sv
// aw_out_counter
//   Up/down counter of issued writes still waiting for a B response.
//   Saturates at MAX_OUT and at zero; a decrement at zero sets a sticky
//   underflow flag that only reset clears.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   inc            one write issued this cycle
//   dec            one B handshake this cycle
//   count          current outstanding count
//   err_underflow  sticky: dec seen while count was zero (and no inc)
module aw_out_counter #(
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err_underflow
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            err_underflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count != CNT_W'(MAX_OUT)) begin
                count <= count + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count == '0) begin
                err_underflow <= 1'b1;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aw_block_gate.sv
// aw_block_gate
//   Write-address admission stage in front of the write-transaction
//   tracker. Holds one AW request, withholds issue while the tracker is
//   full or MAX_OUT writes are outstanding, and serialises BLOCK writes:
//   a BLOCK waits for all earlier writes to complete, issues alone, and
//   nothing further issues until the tracker raises block_fin (answered
//   with a one-cycle block_ack).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_awvalid/s_awready           master AW handshake
//   s_awid, s_awuser              master AW id and transaction type
//   m_awvalid/m_awready           AW handshake toward interconnect/tracker
//   m_awid, m_awuser              issued id and type (from holding register)
//   bvalid, bready                monitored B channel handshake
//   full                          tracker has no free slot
//   block_fin                     tracker level flag: BLOCK write completed
//   block_ack                     one-cycle acknowledge of block_fin
//   outstanding                   issued writes with no B response yet
//   err_underflow                 sticky: B handshake while outstanding==0
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge. Once m_awvalid is raised it stays high,
// with id/user stable, until that transfer. s_awready may depend
// combinationally on m_awready.
module aw_block_gate
    import aw_block_gate_pkg::*;
#(
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [PID_WIDTH-1:0]     s_awid,
    input  logic [PAWUSER_WIDTH-1:0] s_awuser,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [PID_WIDTH-1:0]     m_awid,
    output logic [PAWUSER_WIDTH-1:0] m_awuser,
    input  logic                     bvalid,
    input  logic                     bready,
    input  logic                     full,
    input  logic                     block_fin,
    output logic                     block_ack,
    output logic [CNT_W-1:0]         outstanding,
    output logic                     err_underflow
);

    logic                     hold_v;
    logic [PID_WIDTH-1:0]     hold_id;
    logic [PAWUSER_WIDTH-1:0] hold_user;
    logic                     valid_held;
    gate_state_t              state;
    gate_state_t              state_nxt;
    logic                     s_fire;
    logic                     m_fire;
    logic                     b_fire;
    logic                     can_issue;
    logic                     offer;

    assign s_fire    = s_awvalid & s_awready;
    assign m_fire    = m_awvalid & m_awready;
    assign b_fire    = bvalid & bready;
    assign can_issue = ~full & (outstanding < CNT_W'(MAX_OUT));

    // The gating terms only decide when a held request is first offered;
    // once offered (valid_held) it stays offered until accepted.
    assign offer = hold_v & (valid_held | can_issue);

    // rst_n is folded in so every output reads 0 while reset is asserted.
    assign s_awready = rst_n & (~hold_v | m_fire);
    assign m_awid    = hold_id;
    assign m_awuser  = hold_user;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PASS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_awvalid = 1'b0;
        block_ack = 1'b0;
        case (state)
            PASS: begin
                if (hold_v && is_block(hold_user)) begin
                    state_nxt = DRAIN;
                end else begin
                    m_awvalid = offer;
                end
            end
            DRAIN: begin
                // A B handshake taking the count from 1 to 0 this cycle
                // counts as drained.
                if (outstanding == '0 || (outstanding == CNT_W'(1) && b_fire)) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_awvalid = offer;
                if (offer && m_awready) begin
                    state_nxt = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (block_fin) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                block_ack = 1'b1;
                state_nxt = PASS;
            end
            default: begin
                state_nxt = PASS;
            end
        endcase
    end

    // Single-entry holding register; a same-cycle accept and issue reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v     <= 1'b0;
            hold_id    <= '0;
            hold_user  <= '0;
            valid_held <= 1'b0;
        end else begin
            valid_held <= m_awvalid & ~m_awready;
            if (s_fire) begin
                hold_v    <= 1'b1;
                hold_id   <= s_awid;
                hold_user <= s_awuser;
            end else if (m_fire) begin
                hold_v <= 1'b0;
            end
        end
    end

    aw_out_counter #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_out_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc           (m_fire),
        .dec           (b_fire),
        .count         (outstanding),
        .err_underflow (err_underflow)
    );

endmodule

// File: tb/tb_aw_block_gate.sv
module tb_aw_block_gate;
    import aw_block_gate_pkg::*;

    localparam int MAX_OUT = 8;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    localparam int PH_NORMAL = 0;
    localparam int PH_DRAIN  = 1;
    localparam int PH_ISSUE  = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_ACK    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     s_awvalid = 1'b0;
    logic                     s_awready;
    logic [PID_WIDTH-1:0]     s_awid = '0;
    logic [PAWUSER_WIDTH-1:0] s_awuser = '0;
    logic                     m_awvalid;
    logic                     m_awready = 1'b1;
    logic [PID_WIDTH-1:0]     m_awid;
    logic [PAWUSER_WIDTH-1:0] m_awuser;
    logic                     bvalid = 1'b0;
    logic                     bready = 1'b1;
    logic                     full = 1'b0;
    logic                     block_fin = 1'b0;
    logic                     block_ack;
    logic [CNT_W-1:0]         outstanding;
    logic                     err_underflow;

    aw_block_gate #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_awvalid     (s_awvalid),
        .s_awready     (s_awready),
        .s_awid        (s_awid),
        .s_awuser      (s_awuser),
        .m_awvalid     (m_awvalid),
        .m_awready     (m_awready),
        .m_awid        (m_awid),
        .m_awuser      (m_awuser),
        .bvalid        (bvalid),
        .bready        (bready),
        .full          (full),
        .block_fin     (block_fin),
        .block_ack     (block_ack),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    logic                     mh_v;
    logic [PID_WIDTH-1:0]     mh_id;
    logic [PAWUSER_WIDTH-1:0] mh_user;
    int                       mcnt;
    logic                     merr;
    int                       phase;
    logic                     mlatch;
    logic                     last_s_fire;
    logic [PID_WIDTH-1:0]     exp_q[$];   // ids seen leaving the DUT, in order

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mh_v    = 1'b0;
        mh_id   = '0;
        mh_user = '0;
        mcnt    = 0;
        merr    = 1'b0;
        phase   = PH_NORMAL;
        mlatch  = 1'b0;
    endtask

    // One clock cycle: inputs already driven at the falling edge; compare
    // just after, then advance the model on the rising edge.
    task automatic step();
        logic e_valid, e_srdy, blk, can, mfire, sfire, bfire;
        #1;
        if (!rst_n) model_reset();
        blk     = (mh_user == BLOCK);
        can     = !full && (mcnt < MAX_OUT);
        e_valid = 1'b0;
        if (rst_n) begin
            if (phase == PH_NORMAL)     e_valid = mh_v && !blk && (mlatch || can);
            else if (phase == PH_ISSUE) e_valid = mh_v && (mlatch || can);
        end
        e_srdy = rst_n && (!mh_v || (e_valid && m_awready));
        chk("m_awvalid", m_awvalid, e_valid);
        chk("s_awready", s_awready, e_srdy);
        if (e_valid || !rst_n) begin
            chk("m_awid", m_awid, mh_id);
            chk("m_awuser", m_awuser, mh_user);
        end
        chk("block_ack", block_ack, rst_n && phase == PH_ACK);
        chk("outstanding", outstanding, mcnt);
        chk("err_underflow", err_underflow, merr);
        if (m_awvalid && m_awready) exp_q.push_back(m_awid);
        mfire = e_valid && m_awready;
        sfire = s_awvalid && e_srdy;
        bfire = bvalid && bready;
        last_s_fire = sfire;
        @(posedge clk);
        if (rst_n) begin
            case (phase)
                PH_NORMAL: if (mh_v && blk) phase = PH_DRAIN;
                PH_DRAIN:  if (mcnt == 0 || (mcnt == 1 && bfire)) phase = PH_ISSUE;
                PH_ISSUE:  if (mfire) phase = PH_WAIT;
                PH_WAIT:   if (block_fin) phase = PH_ACK;
                default:   phase = PH_NORMAL;
            endcase
            mlatch = e_valid && !m_awready;
            if (sfire) begin
                mh_v    = 1'b1;
                mh_id   = s_awid;
                mh_user = s_awuser;
            end else if (mfire) begin
                mh_v = 1'b0;
            end
            if (mfire && !bfire) begin
                if (mcnt < MAX_OUT) mcnt++;
            end else if (bfire && !mfire) begin
                if (mcnt == 0) merr = 1'b1;
                else mcnt--;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int id, input logic [PAWUSER_WIDTH-1:0] user);
        bit done = 0;
        s_awvalid = 1'b1;
        s_awid    = PID_WIDTH'(id);
        s_awuser  = user;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            done = last_s_fire;
        end
        s_awvalid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic b_resp(input int n);
        bvalid = 1'b1;
        bready = 1'b1;
        repeat (n) step();
        bvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        last_s_fire = 1'b0;

        // Reset state
        idle(2);
        chk("rst_s_awready", s_awready, 0);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_s_awready", s_awready, 1);

        // Back-to-back REGULAR stream
        exp_q.delete();
        for (int i = 1; i <= 4; i++) send(i, REGULAR);
        idle(2);
        chk("stream_count", exp_q.size(), 4);
        if (exp_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("stream_order", exp_q[i], i + 1);
        end
        chk("stream_outstanding", outstanding, 4);
        b_resp(4);
        chk("stream_drained", outstanding, 0);

        // Tracker full holds the request
        exp_q.delete();
        full = 1'b1;
        send(5, REGULAR);
        idle(2);
        chk("full_m_awvalid", m_awvalid, 0);
        chk("full_s_awready", s_awready, 0);
        full = 1'b0;
        idle(1);
        chk("full_release_issue", exp_q.size(), 1);
        b_resp(1);

        // BLOCK waits for drain, then issues alone until block_fin
        send(1, REGULAR);
        send(2, REGULAR);
        send(7, BLOCK);
        idle(3);
        chk("blk_drain_valid", m_awvalid, 0);
        chk("blk_drain_cnt", outstanding, 2);
        b_resp(1);
        chk("blk_one_left", m_awvalid, 0);
        b_resp(1);
        chk("blk_issue_valid", m_awvalid, 1);
        chk("blk_issue_id", m_awid, 7);
        exp_q.delete();
        send(3, REGULAR);
        idle(2);
        chk("blk_wait_valid", m_awvalid, 0);
        chk("blk_wait_issued", exp_q.size(), 1);
        block_fin = 1'b1;
        idle(1);
        chk("blk_ack_pulse", block_ack, 1);
        idle(1);
        chk("blk_ack_done", block_ack, 0);
        chk("blk_next_valid", m_awvalid, 1);
        chk("blk_next_id", m_awid, 3);
        idle(1);
        block_fin = 1'b0;
        b_resp(2);

        // MAX_OUT limit and simultaneous issue + B
        for (int i = 0; i < MAX_OUT; i++) send(i, DIVERT);
        idle(1);
        send(9, 2'b11);
        idle(2);
        chk("max_out_valid", m_awvalid, 0);
        chk("max_out_cnt", outstanding, MAX_OUT);
        b_resp(1);
        chk("max_out_after_b", outstanding, MAX_OUT - 1);
        chk("max_out_released", m_awvalid, 1);
        b_resp(1);
        chk("fire_and_b_cnt", outstanding, MAX_OUT - 1);
        b_resp(MAX_OUT - 1);

        // Underflow, then reset while waiting for block_fin
        b_resp(1);
        chk("underflow_flag", err_underflow, 1);
        chk("underflow_cnt", outstanding, 0);
        send(2, BLOCK);
        idle(4);
        chk("wait_fin_cnt", outstanding, 1);
        rst_n = 1'b0;
        bvalid = 1'b1;
        idle(1);
        chk("mid_rst_cnt", outstanding, 0);
        chk("mid_rst_err", err_underflow, 0);
        chk("mid_rst_valid", m_awvalid, 0);
        bvalid = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(6, REGULAR);
        chk("after_rst_pass_valid", m_awvalid, 1);
        chk("after_rst_pass_id", m_awid, 6);
        idle(2);
        b_resp(1);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            s_awvalid = 1'($urandom_range(0, 1));
            s_awid    = PID_WIDTH'($urandom_range(0, 15));
            s_awuser  = PAWUSER_WIDTH'($urandom_range(0, 3));
            m_awready = ($urandom_range(0, 3) != 0);
            full      = ($urandom_range(0, 4) == 0);
            bvalid    = (mcnt > 0 || $urandom_range(0, 40) == 0) && ($urandom_range(0, 2) == 0);
            bready    = ($urandom_range(0, 3) != 0);
            block_fin = ($urandom_range(0, 5) == 0);
            step();
        end
        s_awvalid = 1'b0;
        bvalid    = 1'b0;
        block_fin = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
